stack_mem_initiator: RTL and testbench

CPU-side initiator for the data-memory/stack block. It accepts one decoded memory instruction at a time (LW, SW, PUSH, POP, CALL, RET) and computes the effective address, return address and call target. It sequences the memory's opcode, strobe, address and data inputs for exactly one cycle, then captures read data and returns write-back data or a PC redirect to the pipeline. It also tracks stack depth so that overflow and underflow are caught before the memory is touched.

---
 rtl/stack_mem_initiator.sv | 255 +++++++++++++++++++++++++
 tb/tb_stack_mem_initiator.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_mem_initiator.sv
// rtl/stack_mem_initiator.sv - CPU-side initiator sequencing data-memory and stack operations
//
// Accepts one decoded memory instruction at a time (LW, SW, PUSH, POP, CALL, RET),
// computes effective address / return address / call target, drives the memory
// for exactly one ISSUE cycle, captures read data and returns write-back data or
// a PC redirect. Tracks stack depth so overflow/underflow never reaches memory.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   req_valid / req_ready            instruction handshake (ready only in IDLE)
//   req_opcode, req_base, req_imm,
//   req_wdata, req_pc                decoded instruction fields
//   mem_read, mem_write, mem_opcode,
//   mem_addr, mem_wdata, mem_pc      memory drive (idle opcode 6'b111111)
//   mem_rdata                        memory read data, valid the cycle after ISSUE
//   done, err_code                   one-cycle completion pulse and its status
//   wb_en, wb_data                   register write-back (LW, POP)
//   redir_en, redir_pc               PC redirect (CALL, RET)
//   sp_depth                         current stack word count

module stack_mem_initiator #(
    parameter int MEM_BYTES   = 1024,
    parameter int STACK_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_opcode,
    input  logic [31:0] req_base,
    input  logic [15:0] req_imm,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_opcode,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic        wb_en,
    output logic [31:0] wb_data,
    output logic        redir_en,
    output logic [31:0] redir_pc,
    output logic [1:0]  err_code,
    output logic [6:0]  sp_depth
);

    localparam logic [5:0]  OP_LW   = 6'b000101;
    localparam logic [5:0]  OP_SW   = 6'b000110;
    localparam logic [5:0]  OP_PUSH = 6'b001111;
    localparam logic [5:0]  OP_POP  = 6'b010000;
    localparam logic [5:0]  OP_CALL = 6'b010010;
    localparam logic [5:0]  OP_RET  = 6'b010011;
    localparam logic [5:0]  OP_IDLE = 6'b111111;

    localparam logic [31:0] LP_MAX_EA = 32'(MEM_BYTES - 4);
    localparam logic [6:0]  LP_FULL   = 7'(STACK_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [5:0]  r_op;
    logic [31:0] r_ea;
    logic [31:0] r_data;
    logic [31:0] r_ret;
    logic [31:0] r_tgt;
    logic [31:0] r_cap;
    logic [1:0]  r_err;
    logic [6:0]  r_depth;

    logic        w_accept;
    logic [31:0] w_sext_imm;
    logic [31:0] w_ea;
    logic [1:0]  w_acc_err;
    logic        w_known;
    logic        w_is_load;

    assign w_accept   = req_valid && (r_state == S_IDLE);
    assign w_sext_imm = {{16{req_imm[15]}}, req_imm};
    assign w_ea       = req_base + w_sext_imm;

    // Load-type ops need a CAPTURE cycle for the memory's registered read data.
    assign w_is_load  = (r_op == OP_LW) || (r_op == OP_POP) || (r_op == OP_RET);

    // Accept-time checks: any error (or unknown opcode) bypasses the memory entirely.
    always_comb begin
        w_acc_err = 2'd0;
        w_known   = 1'b1;
        case (req_opcode)
            OP_LW, OP_SW: begin
                if ((w_ea[1:0] != 2'b00) || (w_ea > LP_MAX_EA)) begin
                    w_acc_err = 2'd1;
                end
            end
            OP_PUSH, OP_CALL: begin
                if (r_depth == LP_FULL) begin
                    w_acc_err = 2'd2;
                end
            end
            OP_POP, OP_RET: begin
                if (r_depth == 7'd0) begin
                    w_acc_err = 2'd3;
                end
            end
            default: w_known = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if ((w_acc_err != 2'd0) || !w_known) begin
                        w_state_next = S_RESP;
                    end else begin
                        w_state_next = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                w_state_next = w_is_load ? S_CAPTURE : S_RESP;
            end
            S_CAPTURE: w_state_next = S_RESP;
            S_RESP:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op    <= 6'd0;
            r_ea    <= 32'd0;
            r_data  <= 32'd0;
            r_ret   <= 32'd0;
            r_tgt   <= 32'd0;
            r_cap   <= 32'd0;
            r_err   <= 2'd0;
            r_depth <= 7'd0;
        end else begin
            if (w_accept) begin
                r_op   <= req_opcode;
                r_ea   <= w_ea;
                r_data <= req_wdata;
                r_ret  <= req_pc + 32'd4;
                r_tgt  <= req_pc + 32'd4 + {w_sext_imm[29:0], 2'b00};
                r_err  <= w_acc_err;
            end
            // Depth moves only when the memory really performs the stack op,
            // so it stays in lockstep with the memory's own stack pointer.
            if (r_state == S_ISSUE) begin
                if ((r_op == OP_PUSH) || (r_op == OP_CALL)) begin
                    r_depth <= r_depth + 7'd1;
                end else if ((r_op == OP_POP) || (r_op == OP_RET)) begin
                    r_depth <= r_depth - 7'd1;
                end
            end
            if (r_state == S_CAPTURE) begin
                r_cap <= mem_rdata;
            end
        end
    end

    // All outputs decode registered state only; the memory bus is parked on the
    // idle opcode outside ISSUE because the memory acts on opcode alone.
    always_comb begin
        req_ready  = (r_state == S_IDLE);
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_opcode = OP_IDLE;
        mem_addr   = 32'd0;
        mem_wdata  = 32'd0;
        mem_pc     = 32'd0;
        done       = 1'b0;
        wb_en      = 1'b0;
        wb_data    = 32'd0;
        redir_en   = 1'b0;
        redir_pc   = 32'd0;
        err_code   = 2'd0;
        sp_depth   = r_depth;

        if (r_state == S_ISSUE) begin
            case (r_op)
                OP_LW: begin
                    mem_opcode = OP_LW;
                    mem_read   = 1'b1;
                    mem_addr   = r_ea;
                end
                OP_SW: begin
                    mem_opcode = OP_SW;
                    mem_write  = 1'b1;
                    mem_addr   = r_ea;
                    mem_wdata  = r_data;
                end
                OP_PUSH: begin
                    mem_opcode = OP_PUSH;
                    mem_wdata  = r_data;
                end
                OP_POP, OP_RET: begin
                    // The memory has a single pop operation; RET reuses it.
                    mem_opcode = OP_POP;
                end
                OP_CALL: begin
                    mem_opcode = OP_CALL;
                    mem_pc     = r_ret;
                end
                default: begin
                    mem_opcode = OP_IDLE;
                end
            endcase
        end

        if (r_state == S_RESP) begin
            done     = 1'b1;
            err_code = r_err;
            if (r_err == 2'd0) begin
                case (r_op)
                    OP_LW, OP_POP: begin
                        wb_en   = 1'b1;
                        wb_data = r_cap;
                    end
                    OP_RET: begin
                        redir_en = 1'b1;
                        redir_pc = r_cap;
                    end
                    OP_CALL: begin
                        redir_en = 1'b1;
                        redir_pc = r_tgt;
                    end
                    default: begin
                        wb_en = 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stack_mem_initiator.sv
// tb/tb_stack_mem_initiator.sv - randomized scoreboard bench for stack_mem_initiator

module tb_stack_mem_initiator;

    localparam int MEMB = 1024;
    localparam int SD   = 4;

    localparam logic [5:0] LW   = 6'b000101;
    localparam logic [5:0] SW   = 6'b000110;
    localparam logic [5:0] PUSH = 6'b001111;
    localparam logic [5:0] POP  = 6'b010000;
    localparam logic [5:0] CALL = 6'b010010;
    localparam logic [5:0] RET  = 6'b010011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_opcode = 6'd0;
    logic [31:0] req_base = 32'd0;
    logic [15:0] req_imm = 16'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [31:0] req_pc = 32'd0;
    logic        mem_read, mem_write;
    logic [5:0]  mem_opcode;
    logic [31:0] mem_addr, mem_wdata, mem_pc;
    logic [31:0] mem_rdata = 32'd0;
    logic        done, wb_en, redir_en;
    logic [31:0] wb_data, redir_pc;
    logic [1:0]  err_code;
    logic [6:0]  sp_depth;

    stack_mem_initiator #(.MEM_BYTES(MEMB), .STACK_DEPTH(SD)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_base(req_base), .req_imm(req_imm),
        .req_wdata(req_wdata), .req_pc(req_pc), .mem_read(mem_read),
        .mem_write(mem_write), .mem_opcode(mem_opcode), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_pc(mem_pc), .mem_rdata(mem_rdata),
        .done(done), .wb_en(wb_en), .wb_data(wb_data), .redir_en(redir_en),
        .redir_pc(redir_pc), .err_code(err_code), .sp_depth(sp_depth)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Memory device: data array plus hardware stack, responding to the DUT's bus.
    logic [31:0] dev_mem [int unsigned];
    logic [31:0] dev_stk [$];

    always @(posedge clk) begin
        if (!rst_n) begin
            dev_stk.delete();
            mem_rdata <= 32'd0;
        end else begin
            case (mem_opcode)
                LW:   if (mem_read) mem_rdata <= dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : 32'd0;
                SW:   if (mem_write) dev_mem[mem_addr] = mem_wdata;
                PUSH: dev_stk.push_back(mem_wdata);
                CALL: dev_stk.push_back(mem_pc);
                POP:  if (dev_stk.size() > 0) mem_rdata <= dev_stk.pop_back();
                default: ;
            endcase
        end
    end

    typedef struct {
        logic [1:0]  err;
        logic        wb_en;
        logic [31:0] wb;
        logic        redir_en;
        logic [31:0] redir;
        int          lat;
        int          depth;
        logic        has_issue;
        logic        issued;
        logic [5:0]  iop;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] pc;
        int          acc;
    } exp_t;

    exp_t exp_q [$];

    // Reference model: architectural effect of each instruction.
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] ref_stk [$];

    function automatic exp_t model(input logic [5:0] op, input logic [31:0] base,
                                   input logic [15:0] imm, input logic [31:0] wd,
                                   input logic [31:0] pc);
        exp_t e;
        logic [31:0] sx, ea, ret, tgt;
        sx  = {{16{imm[15]}}, imm};
        ea  = base + sx;
        ret = pc + 32'd4;
        tgt = pc + 32'd4 + sx * 32'd4;
        e = '{err: 2'd0, wb_en: 1'b0, wb: 32'd0, redir_en: 1'b0, redir: 32'd0, lat: 1,
              depth: 0, has_issue: 1'b0, issued: 1'b0, iop: 6'd0, rd: 1'b0, wr: 1'b0,
              addr: 32'd0, wd: 32'd0, pc: 32'd0, acc: 0};
        case (op)
            LW, SW: begin
                if ((ea % 4 != 0) || (ea > 32'(MEMB - 4))) e.err = 2'd1;
                else begin
                    e.has_issue = 1'b1; e.iop = op; e.addr = ea;
                    if (op == LW) begin
                        e.rd = 1'b1; e.lat = 3; e.wb_en = 1'b1;
                        e.wb = ref_mem.exists(ea) ? ref_mem[ea] : 32'd0;
                    end else begin
                        e.wr = 1'b1; e.wd = wd; e.lat = 2; ref_mem[ea] = wd;
                    end
                end
            end
            PUSH, CALL: begin
                if (ref_stk.size() == SD) e.err = 2'd2;
                else begin
                    e.has_issue = 1'b1; e.iop = op; e.lat = 2;
                    if (op == PUSH) begin e.wd = wd; ref_stk.push_back(wd); end
                    else begin
                        e.pc = ret; ref_stk.push_back(ret);
                        e.redir_en = 1'b1; e.redir = tgt;
                    end
                end
            end
            POP, RET: begin
                if (ref_stk.size() == 0) e.err = 2'd3;
                else begin
                    e.has_issue = 1'b1; e.iop = POP; e.lat = 3;
                    if (op == POP) begin e.wb_en = 1'b1; e.wb = ref_stk.pop_back(); end
                    else begin e.redir_en = 1'b1; e.redir = ref_stk.pop_back(); end
                end
            end
            default: ;
        endcase
        e.depth = ref_stk.size();
        return e;
    endfunction

    // Issue one instruction at a negedge; keeps junk on req_* while the DUT is busy.
    task automatic send(input logic [5:0] op, input logic [31:0] base, input logic [15:0] imm,
                        input logic [31:0] wd, input logic [31:0] pc, input bit rst_mid);
        exp_t e;
        int n;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
        if (!req_ready) return;
        e = model(op, base, imm, wd, pc);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        req_valid = 1'b1; req_opcode = op; req_base = base;
        req_imm = imm; req_wdata = wd; req_pc = pc;
        @(posedge clk);
        @(negedge clk);
        if (rst_mid) begin
            rst_n = 1'b0;
            req_valid = 1'b0;
            ref_stk.delete();
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
            chk("rst_mid_depth", {25'd0, sp_depth}, 32'd0);
            chk("rst_mid_done", {31'd0, done}, 32'd0);
            return;
        end
        n = 0;
        while (!req_ready && n < 20) begin
            req_valid = 1'($urandom_range(0, 1));
            req_opcode = 6'($urandom); req_base = $urandom;
            req_imm = 16'($urandom); req_wdata = $urandom; req_pc = $urandom;
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (mem_opcode != 6'b111111) begin
                if (exp_q.size() == 0 || !exp_q[0].has_issue) begin
                    chk("unexpected_issue", {26'd0, mem_opcode}, 32'h3f);
                end else begin
                    chk("issue_cycle", 32'(cyc - exp_q[0].acc + 1), 32'd1);
                    chk("issue_opcode", {26'd0, mem_opcode}, {26'd0, exp_q[0].iop});
                    chk("issue_strobes", {30'd0, mem_read, mem_write}, {30'd0, exp_q[0].rd, exp_q[0].wr});
                    chk("issue_addr", mem_addr, exp_q[0].addr);
                    chk("issue_wdata", mem_wdata, exp_q[0].wd);
                    chk("issue_pc", mem_pc, exp_q[0].pc);
                    exp_q[0].issued = 1'b1;
                end
            end else begin
                chk("idle_bus", {27'd0, mem_read, mem_write, |mem_addr, |mem_wdata, |mem_pc}, 32'd0);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", {31'd0, done}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    chk("err_code", {30'd0, err_code}, {30'd0, e.err});
                    chk("issue_seen", {31'd0, e.issued}, {31'd0, e.has_issue});
                    chk("wb_en", {31'd0, wb_en}, {31'd0, e.wb_en});
                    if (e.wb_en) chk("wb_data", wb_data, e.wb);
                    chk("redir_en", {31'd0, redir_en}, {31'd0, e.redir_en});
                    if (e.redir_en) chk("redir_pc", redir_pc, e.redir);
                    chk("sp_depth", {25'd0, sp_depth}, 32'(e.depth));
                end
            end else if (exp_q.size() > 0 && (cyc - exp_q[0].acc + 1) > exp_q[0].lat + 2) begin
                chk("done_timeout", 32'(cyc - exp_q[0].acc + 1), 32'(exp_q[0].lat));
                void'(exp_q.pop_front());
            end
        end
    end

    localparam logic [5:0] OPS [8] = '{LW, SW, PUSH, POP, CALL, RET, 6'b000000, 6'b101010};

    initial begin
        logic [31:0] b;
        logic [5:0]  op;
        rst_n = 1'b0;
        req_valid = 1'b1;
        req_opcode = PUSH;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_opcode", {26'd0, mem_opcode}, 32'h3f);
        chk("rst_hold_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_opcode", {26'd0, mem_opcode}, 32'h3f);
        chk("rst_depth", {25'd0, sp_depth}, 32'd0);
        chk("rst_outputs", {28'd0, done, wb_en, redir_en, |err_code}, 32'd0);

        send(SW,   32'h40, 16'd0, 32'hDEADBEEF, 32'h0, 1'b0);
        send(LW,   32'h3C, 16'd4, 32'h0, 32'h4, 1'b0);
        send(PUSH, 32'h0, 16'd0, 32'h11, 32'h8, 1'b0);
        send(PUSH, 32'h0, 16'd0, 32'h22, 32'hC, 1'b0);
        send(POP,  32'h0, 16'd0, 32'h0, 32'h10, 1'b0);
        send(POP,  32'h0, 16'd0, 32'h0, 32'h14, 1'b0);
        send(CALL, 32'h0, 16'h10, 32'h0, 32'h100, 1'b0);
        send(RET,  32'h0, 16'h0, 32'h0, 32'h144, 1'b0);
        send(POP,  32'h0, 16'd0, 32'h0, 32'h18, 1'b0);
        for (int i = 0; i < 5; i++) send(PUSH, 32'h0, 16'd0, 32'(i + 1), 32'h20, 1'b0);
        for (int i = 0; i < 4; i++) send(POP, 32'h0, 16'd0, 32'h0, 32'h24, 1'b0);
        send(LW,   32'h42, 16'd0, 32'h0, 32'h28, 1'b0);
        send(SW,   32'h400, 16'd0, 32'h5, 32'h2C, 1'b0);
        send(LW,   32'h40, 16'd0, 32'h0, 32'h30, 1'b0);
        send(6'b101010, 32'h40, 16'd0, 32'h0, 32'h34, 1'b0);
        send(LW,   32'h44, 16'hFFFC, 32'h0, 32'h38, 1'b0);
        send(PUSH, 32'h0, 16'd0, 32'h77, 32'h3C, 1'b0);
        send(PUSH, 32'h0, 16'd0, 32'h99, 32'h40, 1'b1);
        send(PUSH, 32'h0, 16'd0, 32'h55, 32'h44, 1'b0);
        send(POP,  32'h0, 16'd0, 32'h0, 32'h48, 1'b0);

        for (int i = 0; i < 300; i++) begin
            op = OPS[$urandom_range(0, 7)];
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, 255)) * 32'd4;
                1: b = 32'($urandom_range(0, 1023));
                2: b = 32'($urandom_range(1000, 1100));
                default: b = $urandom;
            endcase
            send(op, b, 16'($urandom_range(0, 16)) - 16'd8, $urandom,
                 {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 1'b0);
        end

        repeat (10) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
